reset_value_checker: RTL

Parametrised, multi-channel hardware assertion monitor. Every channel checks that its data bus equals a fixed expected value a configurable number of cycles after its trigger rises, the synthesizable equivalent of `$rose(trig) |-> ##DELAY data == EXPECT`. It keeps saturating pass/fail counters, per-channel sticky fail flags and first-failure capture, and can halt on the first failure. It sits beside the datapath under check and reports to the debug/CSR block.

---
 rtl/reset_value_checker.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/reset_value_checker.sv
// reset_value_checker
//   Multi-channel synthesizable assertion monitor. For every channel, a rising
//   edge on trig launches a check. DELAY cycles later the channel's data bus is
//   compared against EXPECT. The block keeps saturating pass/fail counters,
//   per-channel sticky fail flags and a first-failure capture. It can
//   optionally halt checking after the first failure until clear is asserted.
//
// Ports
//   clk              in   rising-edge clock
//   reset_n          in   asynchronous active-low reset
//   enable           in   gates rise detection; low discards pending checks
//   clear            in   synchronous clear of status, counters and pipeline
//   trig             in   [CHANNELS]        per-channel trigger
//   data             in   [CHANNELS*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   pass_cnt         out  [CNT_W]  saturating count of passing checks
//   fail_cnt         out  [CNT_W]  saturating count of failing checks
//   fail_sticky      out  [CHANNELS] per-channel failure seen since clear
//   first_fail_valid out  first-failure capture is loaded
//   first_fail_chan  out  channel of the first failure
//   first_fail_data  out  data sampled at the first failure
//   fail_pulse       out  one-cycle pulse per failing sample cycle
//   halted           out  checker is in the HALTED state
module reset_value_checker #(
  parameter int               WIDTH        = 16,
  parameter int               CHANNELS     = 4,
  parameter int               DELAY        = 0,
  parameter logic [WIDTH-1:0] EXPECT       = '0,
  parameter int               CNT_W        = 16,
  parameter int               HALT_ON_FAIL = 0,
  localparam int              CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       trig,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic [CNT_W-1:0]          pass_cnt,
  output logic [CNT_W-1:0]          fail_cnt,
  output logic [CHANNELS-1:0]       fail_sticky,
  output logic                      first_fail_valid,
  output logic [CHAN_W-1:0]         first_fail_chan,
  output logic [WIDTH-1:0]          first_fail_data,
  output logic                      fail_pulse,
  output logic                      halted
);

  localparam int              PC_W    = $clog2(CHANNELS + 1);
  // The sum needs one bit more than the wider of counter and addend.
  localparam int              SUM_W   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ST_ARMED = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_halted;

  logic [CHANNELS-1:0]   r_trig_q;
  logic [CHANNELS-1:0]   w_rise;
  logic [CHANNELS-1:0]   w_sample;
  logic [CHANNELS-1:0]   w_valid;
  logic [CHANNELS-1:0]   w_pass;
  logic [CHANNELS-1:0]   w_fail;
  logic                  w_any_fail;
  logic                  w_flush;

  logic [PC_W-1:0]       w_pass_n;
  logic [PC_W-1:0]       w_fail_n;
  logic [SUM_W-1:0]      w_pass_sum;
  logic [SUM_W-1:0]      w_fail_sum;
  logic [CNT_W-1:0]      w_pass_next;
  logic [CNT_W-1:0]      w_fail_next;

  logic [CHAN_W-1:0]     w_ff_chan;
  logic [WIDTH-1:0]      w_ff_data;

  logic [CNT_W-1:0]      r_pass_cnt;
  logic [CNT_W-1:0]      r_fail_cnt;
  logic [CHANNELS-1:0]   r_fail_sticky;
  logic                  r_ff_valid;
  logic [CHAN_W-1:0]     r_ff_chan;
  logic [WIDTH-1:0]      r_ff_data;
  logic                  r_fail_pulse;

  // Rise detection; trig_q keeps tracking trig even during clear so that a
  // trigger held across clear is not seen as a fresh rise afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_trig_q <= '0;
    else          r_trig_q <= trig;
  end

  assign w_rise  = trig & ~r_trig_q & {CHANNELS{enable & ~w_halted}};
  assign w_flush = clear | ~enable | w_halted;

  // Pending-check pipeline: one bit per channel per stage.
  generate
    if (DELAY == 0) begin : g_nodelay
      assign w_sample = w_rise;
    end else begin : g_delay
      logic [CHANNELS-1:0] r_pipe [DELAY];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < DELAY; k++) r_pipe[k] <= '0;
        end else if (w_flush) begin
          for (int k = 0; k < DELAY; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= w_rise;
          for (int k = 1; k < DELAY; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end
      assign w_sample = r_pipe[DELAY-1];
    end
  endgenerate

  // A maturing check is discarded while disabled or halted.
  assign w_valid = w_sample & {CHANNELS{enable & ~w_halted}};

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_cmp
      logic w_match;
      assign w_match    = (data[gi*WIDTH +: WIDTH] == EXPECT);
      assign w_pass[gi] = w_valid[gi] &  w_match;
      assign w_fail[gi] = w_valid[gi] & ~w_match;
    end
  endgenerate

  assign w_any_fail = |w_fail;

  // Popcounts, lowest-index failing channel, saturating sums.
  always_comb begin
    w_pass_n  = '0;
    w_fail_n  = '0;
    w_ff_chan = '0;
    w_ff_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_pass_n = w_pass_n + PC_W'(w_pass[k]);
      w_fail_n = w_fail_n + PC_W'(w_fail[k]);
    end
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (w_fail[k]) begin
        w_ff_chan = CHAN_W'(k);
        w_ff_data = data[k*WIDTH +: WIDTH];
      end
    end
    w_pass_sum  = SUM_W'(r_pass_cnt) + SUM_W'(w_pass_n);
    w_fail_sum  = SUM_W'(r_fail_cnt) + SUM_W'(w_fail_n);
    w_pass_next = (w_pass_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_pass_sum[CNT_W-1:0];
    w_fail_next = (w_fail_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_fail_sum[CNT_W-1:0];
  end

  // Status registers; clear wins over any result maturing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pass_cnt    <= '0;
      r_fail_cnt    <= '0;
      r_fail_sticky <= '0;
      r_ff_valid    <= 1'b0;
      r_ff_chan     <= '0;
      r_ff_data     <= '0;
      r_fail_pulse  <= 1'b0;
    end else if (clear) begin
      r_pass_cnt    <= '0;
      r_fail_cnt    <= '0;
      r_fail_sticky <= '0;
      r_ff_valid    <= 1'b0;
      r_ff_chan     <= '0;
      r_ff_data     <= '0;
      r_fail_pulse  <= 1'b0;
    end else begin
      r_pass_cnt    <= w_pass_next;
      r_fail_cnt    <= w_fail_next;
      r_fail_sticky <= r_fail_sticky | w_fail;
      r_fail_pulse  <= w_any_fail;
      if (!r_ff_valid && w_any_fail) begin
        r_ff_valid <= 1'b1;
        r_ff_chan  <= w_ff_chan;
        r_ff_data  <= w_ff_data;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_ARMED;
    else          r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED:  if (HALT_ON_FAIL != 0 && w_any_fail) w_state_next = ST_HALTED;
        ST_HALTED: w_state_next = ST_HALTED;
        default:   w_state_next = ST_ARMED;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    w_halted = (r_state == ST_HALTED);
  end

  assign pass_cnt         = r_pass_cnt;
  assign fail_cnt         = r_fail_cnt;
  assign fail_sticky      = r_fail_sticky;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_chan  = r_ff_chan;
  assign first_fail_data  = r_ff_data;
  assign fail_pulse       = r_fail_pulse;
  assign halted           = w_halted;

endmodule
